// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer,
// OR-combined flush inputs and a saturating flush-event counter.
module pipe_stage_skid #(
  parameter int unsigned CTRL_W     = 17,
  parameter int unsigned DATA_W     = 235,
  parameter int unsigned NFLUSH     = 2,
  parameter int unsigned CLEAR_DATA = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  input  logic [NFLUSH-1:0] Flush,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [1:0]        Occupancy,
  output logic [CNT_W-1:0]  FlushCnt
);

  // Encoding equals the number of entries held, so Occupancy is the state register itself.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0]   head_data_q, head_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic flush_any;
  logic accept;
  logic drain;

  assign flush_any = |Flush;
  assign accept    = In_Valid & In_Ready;
  assign drain     = Out_Valid & Out_Ready;

  always_comb begin
    state_d     = state_q;
    head_ctrl_d = head_ctrl_q;
    head_data_d = head_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush_any) begin
      // Flush wins over accept and drain; a same-cycle drain was already seen downstream.
      state_d     = StEmpty;
      head_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA != 0) begin
        head_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d     = StOne;
            head_ctrl_d = In_Ctrl;
            head_data_d = In_Data;
          end
        end
        StOne: begin
          if (accept && drain) begin
            head_ctrl_d = In_Ctrl;
            head_data_d = In_Data;
          end else if (accept) begin
            state_d     = StFull;
            skid_ctrl_d = In_Ctrl;
            skid_data_d = In_Data;
          end else if (drain) begin
            state_d     = StEmpty;
            head_ctrl_d = '0;
            if (CLEAR_DATA != 0) begin
              head_data_d = '0;
            end
          end
        end
        StFull: begin
          if (drain) begin
            state_d     = StOne;
            head_ctrl_d = skid_ctrl_q;
            head_data_d = skid_data_q;
            skid_ctrl_d = '0;
            skid_data_d = '0;
          end
        end
        default: begin
          state_d     = StEmpty;
          head_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush_any && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StEmpty;
      head_ctrl_q <= '0;
      head_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      head_ctrl_q <= head_ctrl_d;
      head_data_q <= head_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign In_Ready  = (state_q != StFull);
  assign Out_Valid = (state_q != StEmpty);
  assign Out_Ctrl  = head_ctrl_q;
  assign Out_Data  = head_data_q;
  assign Occupancy = state_q;
  assign FlushCnt  = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a clearing instance (CLEAR_DATA=1, CNT_W=16) and a holding
// instance (CLEAR_DATA=0, CNT_W=4) share stimulus and are compared to a queue model.
module tb_pipe_stage_skid;

  localparam int CW = 17;
  localparam int DW = 235;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } ent_t;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          In_Valid = 1'b0;
  logic [CW-1:0] In_Ctrl = '0;
  logic [DW-1:0] In_Data = '0;
  logic [1:0]    Flush = '0;
  logic          Out_Ready = 1'b0;

  logic          c_in_ready, c_out_valid, h_in_ready, h_out_valid;
  logic [CW-1:0] c_ctrl, h_ctrl;
  logic [DW-1:0] c_data, h_data;
  logic [1:0]    c_occ, h_occ;
  logic [15:0]   c_cnt;
  logic [3:0]    h_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .NFLUSH(2), .CLEAR_DATA(1), .CNT_W(16)) dut_c (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(c_in_ready), .In_Ctrl(In_Ctrl),
    .In_Data(In_Data), .Flush(Flush), .Out_Valid(c_out_valid), .Out_Ready(Out_Ready),
    .Out_Ctrl(c_ctrl), .Out_Data(c_data), .Occupancy(c_occ), .FlushCnt(c_cnt)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .NFLUSH(2), .CLEAR_DATA(0), .CNT_W(4)) dut_h (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(h_in_ready), .In_Ctrl(In_Ctrl),
    .In_Data(In_Data), .Flush(Flush), .Out_Valid(h_out_valid), .Out_Ready(Out_Ready),
    .Out_Ctrl(h_ctrl), .Out_Data(h_data), .Occupancy(h_occ), .FlushCnt(h_cnt)
  );

  // Reference model: FIFO of at most two entries, a flush event count, and the last head data.
  ent_t          mq[$];
  int            m_flushes;
  logic [DW-1:0] m_last;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mq.delete();
      m_flushes = 0;
      m_last = '0;
    end else begin
      bit rdy;
      bit vld;
      rdy = (mq.size() < 2);
      vld = (mq.size() > 0);
      if (|Flush) begin
        m_flushes++;
        mq.delete();
      end else begin
        if (vld && Out_Ready) void'(mq.pop_front());
        if (In_Valid && rdy) mq.push_back({In_Ctrl, In_Data});
      end
      if (mq.size() > 0) m_last = mq[0].data;
    end
  end

  function automatic logic [CW+3:0] e_status();
    logic [CW-1:0] ctl;
    ctl = (mq.size() > 0) ? mq[0].ctrl : '0;
    return {mq.size() > 0, mq.size() < 2, 2'(mq.size()), ctl};
  endfunction

  function automatic logic [DW-1:0] e_data(bit clr);
    if (mq.size() > 0) return mq[0].data;
    return clr ? '0 : m_last;
  endfunction

  function automatic logic [15:0] e_cnt16();
    return (m_flushes > 65535) ? 16'hFFFF : 16'(m_flushes);
  endfunction

  function automatic logic [3:0] e_cnt4();
    return (m_flushes > 15) ? 4'hF : 4'(m_flushes);
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    // Inputs ignored while Reset is high
    In_Valid = 1'b1; In_Data = 235'h5; In_Ctrl = 17'h3; Flush = 2'b01;
    tick();
    n_total++;
    if ({c_out_valid, c_occ, c_ctrl, c_data, c_cnt} !== '0)
      $display("FAIL reset_hold: got v=%0b occ=%0d ctrl=%0h cnt=%0d want all zero",
               c_out_valid, c_occ, c_ctrl, c_cnt);
    else n_pass++;
    Reset = 1'b0; In_Valid = 1'b0; Flush = 2'b00;
    #1;
    n_total++;
    if (c_in_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", c_in_ready);
    else n_pass++;
    // Make the counter nonzero, then fill to two entries
    Flush = 2'b01; tick(); Flush = 2'b00;
    Out_Ready = 1'b0; In_Valid = 1'b1;
    In_Data = 235'hA1; In_Ctrl = 17'h11; tick();
    In_Data = 235'hB2; In_Ctrl = 17'h22; tick();
    In_Valid = 1'b0;
    n_total++;
    if ({c_occ, c_cnt} !== {2'd2, 16'd1})
      $display("FAIL reset_prefill: got occ=%0d cnt=%0d want occ=2 cnt=1", c_occ, c_cnt);
    else n_pass++;
    Reset = 1'b1;
    #1;
    n_total++;
    if ({c_out_valid, c_ctrl, c_data, c_cnt, c_occ} !== '0)
      $display("FAIL reset_async: got v=%0b ctrl=%0h data=%0h cnt=%0d occ=%0d want zeros",
               c_out_valid, c_ctrl, c_data, c_cnt, c_occ);
    else n_pass++;
    #2;
    Reset = 1'b0;
    #1;
    n_total++;
    if ({c_in_ready, h_in_ready} !== 2'b11)
      $display("FAIL reset_release_ready: got %0b%0b want 11", c_in_ready, h_in_ready);
    else n_pass++;
  endtask

  task automatic test_streaming();
    Out_Ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      In_Valid = 1'b1; In_Data = DW'(i); In_Ctrl = CW'($urandom);
      tick();
      n_total++;
      if ({c_out_valid, c_in_ready, c_data} !== {1'b1, 1'b1, DW'(i)})
        $display("FAIL stream_%0d: got v=%0b rdy=%0b data=%0h want v=1 rdy=1 data=%0h",
                 i, c_out_valid, c_in_ready, c_data, i);
      else n_pass++;
      n_total++;
      if (c_ctrl !== In_Ctrl) $display("FAIL stream_ctrl_%0d: got %0h want %0h", i, c_ctrl, In_Ctrl);
      else n_pass++;
    end
    In_Valid = 1'b0;
    tick();
    n_total++;
    if ({c_out_valid, c_occ, c_ctrl, c_data} !== '0)
      $display("FAIL stream_empty: got v=%0b occ=%0d ctrl=%0h want zeros", c_out_valid, c_occ, c_ctrl);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b;
    a = rand_data(); b = rand_data();
    Out_Ready = 1'b0; In_Valid = 1'b1;
    In_Data = a; In_Ctrl = 17'h1A; tick();
    In_Data = b; In_Ctrl = 17'h1B; tick();
    In_Valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({c_occ, c_in_ready, c_out_valid, c_ctrl, c_data} !== {2'd2, 1'b0, 1'b1, 17'h1A, a})
        $display("FAIL bp_full_%0d: got occ=%0d rdy=%0b ctrl=%0h data=%0h want occ=2 rdy=0 ctrl=1a data=%0h",
                 k, c_occ, c_in_ready, c_ctrl, c_data, a);
      else n_pass++;
      tick();
    end
    Out_Ready = 1'b1;
    tick();
    n_total++;
    if ({c_occ, c_in_ready, c_ctrl, c_data} !== {2'd1, 1'b1, 17'h1B, b})
      $display("FAIL bp_drain1: got occ=%0d rdy=%0b ctrl=%0h data=%0h want occ=1 rdy=1 ctrl=1b data=%0h",
               c_occ, c_in_ready, c_ctrl, c_data, b);
    else n_pass++;
    tick();
    n_total++;
    if ({c_occ, c_out_valid} !== 3'b000)
      $display("FAIL bp_drain2: got occ=%0d v=%0b want occ=0 v=0", c_occ, c_out_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [15:0] cnt0;
    cnt0 = c_cnt;
    Out_Ready = 1'b0; In_Valid = 1'b1;
    In_Data = rand_data(); In_Ctrl = 17'h0F0; tick();
    In_Data = rand_data(); In_Ctrl = 17'h0F1; tick();
    Flush = 2'b10; In_Data = 235'hC3; In_Ctrl = 17'h0F2;
    tick();
    Flush = 2'b00; In_Valid = 1'b0;
    n_total++;
    if ({c_occ, c_out_valid, c_ctrl, c_data} !== '0)
      $display("FAIL flush_full: got occ=%0d v=%0b ctrl=%0h data=%0h want zeros",
               c_occ, c_out_valid, c_ctrl, c_data);
    else n_pass++;
    n_total++;
    if (c_cnt !== cnt0 + 16'd1) $display("FAIL flush_cnt: got %0d want %0d", c_cnt, cnt0 + 16'd1);
    else n_pass++;
    tick();
    n_total++;
    if ({c_occ, c_out_valid} !== 3'b000)
      $display("FAIL flush_dropped: got occ=%0d v=%0b want occ=0 v=0", c_occ, c_out_valid);
    else n_pass++;
  endtask

  task automatic test_clear_data_hold();
    logic [DW-1:0] d;
    d = rand_data();
    d[31:0] = 32'hDEADBEEF;
    Out_Ready = 1'b0; In_Valid = 1'b1; In_Data = d; In_Ctrl = 17'h1FFFF;
    tick();
    In_Valid = 1'b0; Flush = 2'b01;
    tick();
    Flush = 2'b00;
    n_total++;
    if ({h_out_valid, h_ctrl, h_data[31:0]} !== {1'b0, 17'h0, 32'hDEADBEEF})
      $display("FAIL hold_flush: got v=%0b ctrl=%0h data=%0h want v=0 ctrl=0 data=deadbeef",
               h_out_valid, h_ctrl, h_data[31:0]);
    else n_pass++;
    n_total++;
    if (c_data !== '0) $display("FAIL clear_flush: got %0h want 0", c_data);
    else n_pass++;
  endtask

  task automatic test_counter_saturation();
    Reset = 1'b1; #2; Reset = 1'b0;
    Flush = 2'b11;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14 || i == 20) begin
        n_total++;
        if (h_cnt !== ((i > 15) ? 4'd15 : 4'(i)))
          $display("FAIL cnt4_%0d: got %0d want %0d", i, h_cnt, (i > 15) ? 15 : i);
        else n_pass++;
        n_total++;
        if (c_cnt !== 16'(i)) $display("FAIL cnt16_%0d: got %0d want %0d", i, c_cnt, i);
        else n_pass++;
      end
    end
    Flush = 2'b00;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      In_Valid = ($urandom_range(9) < 7);
      Out_Ready = ($urandom_range(9) < 6);
      In_Ctrl = CW'($urandom);
      In_Data = rand_data();
      Flush = ($urandom_range(15) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      tick();
      n_total++;
      if ({c_out_valid, c_in_ready, c_occ, c_ctrl} !== e_status())
        $display("FAIL rnd_c_status @%0d: got %0h want %0h", cyc,
                 {c_out_valid, c_in_ready, c_occ, c_ctrl}, e_status());
      else n_pass++;
      n_total++;
      if ({h_out_valid, h_in_ready, h_occ, h_ctrl} !== e_status())
        $display("FAIL rnd_h_status @%0d: got %0h want %0h", cyc,
                 {h_out_valid, h_in_ready, h_occ, h_ctrl}, e_status());
      else n_pass++;
      n_total++;
      if (c_data !== e_data(1'b1))
        $display("FAIL rnd_c_data @%0d: got %0h want %0h", cyc, c_data, e_data(1'b1));
      else n_pass++;
      n_total++;
      if (h_data !== e_data(1'b0))
        $display("FAIL rnd_h_data @%0d: got %0h want %0h", cyc, h_data, e_data(1'b0));
      else n_pass++;
      n_total++;
      if ({c_cnt, h_cnt} !== {e_cnt16(), e_cnt4()})
        $display("FAIL rnd_cnt @%0d: got %0d/%0d want %0d/%0d", cyc, c_cnt, h_cnt,
                 e_cnt16(), e_cnt4());
      else n_pass++;
    end
    In_Valid = 1'b0; Flush = 2'b00;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_clear_data_hold();
    test_counter_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
